// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
//   estado_t      : per-slot phase (blanking / lit)
//   HAB_BAJA/ALTA : values of the HAB_ACTIVA enable-polarity parameter
//   clog2_f       : ceiling log2, used to size counters and the digit index
package display_pkg;

  typedef enum logic {
    APAGADO   = 1'b0,
    ENCENDIDO = 1'b1
  } estado_t;

  localparam int unsigned HAB_BAJA = 0;
  localparam int unsigned HAB_ALTA = 1;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divisor_barrido.sv
// Scan prescaler: counts 0..DIV_BARRIDO-1 and wraps.
//   clk_i, rst_i   : system clock, asynchronous active-high reset
//   fin_ranura_o   : high in the last cycle of a digit slot (count wraps next)
//   en_apagado_o   : high while the count is inside the blanking window
module divisor_barrido
  import display_pkg::*;
#(
  parameter int unsigned DIV_BARRIDO = 50000,
  parameter int unsigned T_APAGADO   = 500
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic fin_ranura_o,
  output logic en_apagado_o
);

  localparam int unsigned W = clog2_f(DIV_BARRIDO);

  logic [W-1:0] cnt_q, cnt_d;

  assign fin_ranura_o = (cnt_q == W'(DIV_BARRIDO - 1));
  assign en_apagado_o = (cnt_q <  W'(T_APAGADO));

  always_comb begin
    cnt_d = fin_ranura_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/controlador_barrido_display.sv
// Self-timed scan controller for an N-digit multiplexed 7-segment display.
//   i_Clk, i_Reset : system clock, asynchronous active-high reset
//   i_Datos        : digit codes, digit k at [k*ANCHO_CIFRA +: ANCHO_CIFRA], k=0 is LSD
//   i_Puntos       : decimal point per digit
//   i_Cargar       : load strobe into the staging buffer
//   i_Supr_ceros   : blank leading zeros
//   o_Cifra        : code of the enabled digit (0 while blanking)
//   o_Punto        : decimal point of the enabled digit
//   o_Habs         : one-hot digit enable, polarity set by HAB_ACTIVA
//   o_N_cifra      : current slot index
//   o_Fin_trama    : pulse in the last cycle of the last slot
module controlador_barrido_display
  import display_pkg::*;
#(
  parameter int unsigned N_CIFRAS    = 4,
  parameter int unsigned ANCHO_CIFRA = 4,
  parameter int unsigned DIV_BARRIDO = 50000,
  parameter int unsigned T_APAGADO   = 500,
  parameter int unsigned HAB_ACTIVA  = 0
) (
  input  logic                            i_Clk,
  input  logic                            i_Reset,
  input  logic [N_CIFRAS*ANCHO_CIFRA-1:0] i_Datos,
  input  logic [N_CIFRAS-1:0]             i_Puntos,
  input  logic                            i_Cargar,
  input  logic                            i_Supr_ceros,
  output logic [ANCHO_CIFRA-1:0]          o_Cifra,
  output logic                            o_Punto,
  output logic [N_CIFRAS-1:0]             o_Habs,
  output logic [clog2_f(N_CIFRAS)-1:0]    o_N_cifra,
  output logic                            o_Fin_trama
);

  localparam int unsigned IW = clog2_f(N_CIFRAS);
  localparam int unsigned DW = N_CIFRAS * ANCHO_CIFRA;
  localparam logic [N_CIFRAS-1:0] HABS_OFF = (HAB_ACTIVA == HAB_ALTA) ? '0 : '1;

  logic fin_ranura, en_apagado, fin_trama;

  divisor_barrido #(
    .DIV_BARRIDO(DIV_BARRIDO),
    .T_APAGADO  (T_APAGADO)
  ) u_divisor (
    .clk_i       (i_Clk),
    .rst_i       (i_Reset),
    .fin_ranura_o(fin_ranura),
    .en_apagado_o(en_apagado)
  );

  // Slot index
  logic [IW-1:0] idx_q, idx_d;

  assign fin_trama = fin_ranura && (idx_q == IW'(N_CIFRAS - 1));

  always_comb begin
    idx_d = idx_q;
    if (fin_ranura) idx_d = fin_trama ? '0 : idx_q + IW'(1);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) idx_q <= '0;
    else         idx_q <= idx_d;
  end

  // Double buffer: staging takes every strobe, display only changes at a frame
  // boundary so a frame is never split between old and new data. A strobe in
  // the boundary cycle itself goes straight to the display.
  logic [DW-1:0]       stg_datos_q, stg_datos_d, disp_datos_q, disp_datos_d;
  logic [N_CIFRAS-1:0] stg_puntos_q, stg_puntos_d, disp_puntos_q, disp_puntos_d;
  logic                pend_q, pend_d;

  always_comb begin
    stg_datos_d   = stg_datos_q;
    stg_puntos_d  = stg_puntos_q;
    disp_datos_d  = disp_datos_q;
    disp_puntos_d = disp_puntos_q;
    pend_d        = pend_q;
    if (i_Cargar) begin
      stg_datos_d  = i_Datos;
      stg_puntos_d = i_Puntos;
      pend_d       = 1'b1;
    end
    if (fin_trama) begin
      if (i_Cargar) begin
        disp_datos_d  = i_Datos;
        disp_puntos_d = i_Puntos;
      end else if (pend_q) begin
        disp_datos_d  = stg_datos_q;
        disp_puntos_d = stg_puntos_q;
      end
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      stg_datos_q   <= '0;
      stg_puntos_q  <= '0;
      disp_datos_q  <= '0;
      disp_puntos_q <= '0;
      pend_q        <= 1'b0;
    end else begin
      stg_datos_q   <= stg_datos_d;
      stg_puntos_q  <= stg_puntos_d;
      disp_datos_q  <= disp_datos_d;
      disp_puntos_q <= disp_puntos_d;
      pend_q        <= pend_d;
    end
  end

  // Current digit selection and leading-zero suppression
  logic [N_CIFRAS-1:0]    habs_sel;
  logic [ANCHO_CIFRA-1:0] cifra_sel;
  logic                   punto_sel, ceros_arriba, suprimir;

  always_comb begin
    habs_sel     = '0;
    cifra_sel    = '0;
    punto_sel    = 1'b0;
    ceros_arriba = 1'b1;
    for (int unsigned k = 0; k < N_CIFRAS; k++) begin
      if (IW'(k) == idx_q) begin
        habs_sel[k] = 1'b1;
        cifra_sel   = disp_datos_q[k*ANCHO_CIFRA +: ANCHO_CIFRA];
        punto_sel   = disp_puntos_q[k];
      end
      if (IW'(k) >= idx_q && disp_datos_q[k*ANCHO_CIFRA +: ANCHO_CIFRA] != '0)
        ceros_arriba = 1'b0;
    end
    suprimir = i_Supr_ceros && (idx_q != '0) && ceros_arriba;
  end

  // Phase FSM; state_q tracks the phase currently shown on the registered outputs
  estado_t estado_q, estado_d;

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      APAGADO:   if (!en_apagado) estado_d = ENCENDIDO;
      ENCENDIDO: if (en_apagado)  estado_d = APAGADO;
    endcase
  end

  logic [N_CIFRAS-1:0]    habs_q;
  logic [ANCHO_CIFRA-1:0] cifra_q;
  logic                   punto_q, fin_q;
  logic [IW-1:0]          ncifra_q;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      estado_q <= APAGADO;
      habs_q   <= HABS_OFF;
      cifra_q  <= '0;
      punto_q  <= 1'b0;
      ncifra_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      ncifra_q <= idx_q;
      fin_q    <= fin_trama;
      if (estado_d == ENCENDIDO) begin
        // A suppressed digit keeps its slot time but stays dark
        habs_q  <= suprimir ? HABS_OFF
                 : ((HAB_ACTIVA == HAB_ALTA) ? habs_sel : ~habs_sel);
        cifra_q <= cifra_sel;
        punto_q <= punto_sel && !suprimir;
      end else begin
        habs_q  <= HABS_OFF;
        cifra_q <= '0;
        punto_q <= 1'b0;
      end
    end
  end

  assign o_Habs      = habs_q;
  assign o_Cifra     = cifra_q;
  assign o_Punto     = punto_q;
  assign o_N_cifra   = ncifra_q;
  assign o_Fin_trama = fin_q;

endmodule
